// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin byte mux front end: channel ids,
// channel count and the default byte width.
package rr_mux_arbiter_pkg;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [1:0] ch_id_t;

  localparam ch_id_t CH_A = 2'd0;
  localparam ch_id_t CH_B = 2'd1;
  localparam ch_id_t CH_C = 2'd2;
  localparam ch_id_t CH_D = 2'd3;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Source-side valid/ready channels, mux select and registered output handshake
// of the round-robin arbiter.
interface rr_mux_arbiter_if #(
   parameter int unsigned DATA_W = 8
);
   logic [3:0]        req_valid;
   logic [3:0]        req_ready;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic [DATA_W-1:0] c_in;
   logic [DATA_W-1:0] d_in;
   logic [1:0]        sel_o;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        grant_id;

   modport slave (
      input  req_valid, a_in, b_in, c_in, d_in, out_ready,
      output req_ready, sel_o, out_data, out_valid, grant_id
   );

   modport master (
      output req_valid, a_in, b_in, c_in, d_in, out_ready,
      input  req_ready, sel_o, out_data, out_valid, grant_id
   );
endinterface

// File: rtl/rr_mux_arbiter_mux4.sv
// Plain 4:1 byte mux selecting one of four channels by channel id.
module Mux4x1
   import rr_mux_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [DATA_W-1:0] i_c,
   input  logic [DATA_W-1:0] i_d,
   input  ch_id_t            i_sel,
   output logic [DATA_W-1:0] o_y
);
   always_comb begin
      o_y = '0;
      unique case (i_sel)
         CH_A: o_y = i_a;
         CH_B: o_y = i_b;
         CH_C: o_y = i_c;
         CH_D: o_y = i_d;
      endcase
   end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with burst cap for four byte sources; drives the mux
// select and registers the selected byte into a one-entry output stage.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned BURST_LEN = 1
) (
   input  logic           clk,
   input  logic           rst,
   rr_mux_arbiter_if.slave bus
);
   localparam logic [3:0] BurstCap = 4'(BURST_LEN);

   // Returns {found, channel}; stays on ptr while a burst is open, else
   // scans ptr+1 .. ptr so ptr itself has lowest priority.
   function automatic logic [2:0] next_grant(input ch_id_t            ptr,
                                             input logic [3:0]        cnt,
                                             input logic [NUM_CH-1:0] valid);
      logic [2:0] res;
      ch_id_t     idx;
      res = 3'b000;
      if (cnt != 4'd0 && valid[ptr] && cnt < BurstCap) begin
         res = {1'b1, ptr};
      end else begin
         for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!res[2] && valid[idx]) res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   ch_id_t            r_grant_id;
   ch_id_t            r_ptr;
   logic [3:0]        r_burst_cnt;

   logic              w_load_ok;
   logic              w_grant;
   logic [2:0]        w_pick;
   ch_id_t            w_g;
   ch_id_t            w_sel;
   logic [DATA_W-1:0] w_mux;

   always_comb begin
      w_load_ok = ~r_out_valid | bus.out_ready;
      w_pick    = next_grant(r_ptr, r_burst_cnt, bus.req_valid);
      w_g       = w_pick[1:0];
      w_grant   = ~rst & w_load_ok & w_pick[2];
      // Hold select on the last winner when idle so the mux never glitches.
      w_sel     = w_grant ? w_g : r_grant_id;
   end

   Mux4x1 #(
      .DATA_W(DATA_W)
   ) u_mux (
      .i_a  (bus.a_in),
      .i_b  (bus.b_in),
      .i_c  (bus.c_in),
      .i_d  (bus.d_in),
      .i_sel(w_sel),
      .o_y  (w_mux)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_grant_id  <= CH_A;
         r_ptr       <= CH_D;
         r_burst_cnt <= 4'd0;
      end else if (w_grant) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_mux;
         r_grant_id  <= w_g;
         if (w_g == r_ptr && r_burst_cnt != 4'd0) begin
            if (r_burst_cnt < BurstCap) r_burst_cnt <= r_burst_cnt + 4'd1;
         end else begin
            r_ptr       <= w_g;
            r_burst_cnt <= 4'd1;
         end
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.req_ready = w_grant ? (4'b0001 << w_g) : 4'b0000;
   assign bus.sel_o     = w_sel;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.grant_id  = r_grant_id;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench: dut1 runs pure round-robin, dut2 runs bursts of three;
// both share the same stimulus.
module tb_rr_mux_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req_valid = 4'b0000;
   logic       out_ready = 1'b0;
   logic [7:0] a_in = 8'h11, b_in = 8'h22, c_in = 8'h33, d_in = 8'h44;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter_if #(.DATA_W(8)) bus1 ();
   rr_mux_arbiter_if #(.DATA_W(8)) bus2 ();

   assign bus1.req_valid = req_valid;
   assign bus1.out_ready = out_ready;
   assign bus1.a_in = a_in;
   assign bus1.b_in = b_in;
   assign bus1.c_in = c_in;
   assign bus1.d_in = d_in;
   assign bus2.req_valid = req_valid;
   assign bus2.out_ready = out_ready;
   assign bus2.a_in = a_in;
   assign bus2.b_in = b_in;
   assign bus2.c_in = c_in;
   assign bus2.d_in = d_in;

   rr_mux_arbiter #(.DATA_W(8), .BURST_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   rr_mux_arbiter #(.DATA_W(8), .BURST_LEN(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req_valid = 4'b0000;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (bus1.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_req_ready: got %b want 0000", bus1.req_ready);
      end
      checks++;
      if (bus1.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b want 0", bus1.out_valid);
      end
      checks++;
      if (bus1.out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_out_data: got %h want 00", bus1.out_data);
      end
      checks++;
      if (bus2.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_req_ready2: got %b want 0000", bus2.req_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus1.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant: got %b want 0001", bus1.req_ready);
      end
      tick();
      checks++;
      if (bus1.out_data !== 8'h11 || bus1.grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_data: got %h/%0d want 11/0", bus1.out_data, bus1.grant_id);
      end
   endtask

   task automatic test_round_robin;
      logic [7:0] exp_d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      logic [1:0] exp_g[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bus1.out_data !== exp_d[i] || bus1.grant_id !== exp_g[i] || bus1.out_valid !== 1'b1)
         begin
            errors++;
            $display("FAIL rr_step%0d: got %h/%0d/%b want %h/%0d/1", i, bus1.out_data,
                     bus1.grant_id, bus1.out_valid, exp_d[i], exp_g[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset();
      req_valid = 4'b1111;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus1.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_req_ready%0d: got %b want 0000", i, bus1.req_ready);
         end
         tick();
         checks++;
         if (bus1.out_data !== 8'h11 || bus1.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d: got %h/%b want 11/1", i, bus1.out_data, bus1.out_valid);
         end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (bus1.out_data !== 8'h22 || bus1.grant_id !== 2'd1) begin
         errors++;
         $display("FAIL bp_release: got %h/%0d want 22/1", bus1.out_data, bus1.grant_id);
      end
   endtask

   task automatic test_burst;
      logic [1:0] exp_g[7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
      do_reset();
      req_valid = 4'b0011;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (bus2.grant_id !== exp_g[i] ||
             bus2.out_data !== ((exp_g[i] == 2'd0) ? 8'h11 : 8'h22)) begin
            errors++;
            $display("FAIL burst_step%0d: got %0d/%h want %0d", i, bus2.grant_id,
                     bus2.out_data, exp_g[i]);
         end
      end
      req_valid = 4'b0010;
      tick();
      checks++;
      if (bus2.grant_id !== 2'd1 || bus2.out_data !== 8'h22) begin
         errors++;
         $display("FAIL burst_drop: got %0d/%h want 1/22", bus2.grant_id, bus2.out_data);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      req_valid = 4'b0100;
      out_ready = 1'b1;
      tick();
      req_valid = 4'b0010;
      #1;
      checks++;
      if (bus1.sel_o !== 2'b01 || bus1.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL wrap_sel: got %b/%b want 01/0010", bus1.sel_o, bus1.req_ready);
      end
      tick();
      checks++;
      if (bus1.out_data !== 8'h22 || bus1.grant_id !== 2'd1) begin
         errors++;
         $display("FAIL wrap_data: got %h/%0d want 22/1", bus1.out_data, bus1.grant_id);
      end
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      req_valid = 4'b0100;
      out_ready = 1'b0;
      tick();
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.out_data !== 8'h33) begin
         errors++;
         $display("FAIL mid_load: got %b/%h want 1/33", bus2.out_valid, bus2.out_data);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus2.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL mid_rst_ready: got %b want 0000", bus2.req_ready);
      end
      tick();
      checks++;
      if (bus2.out_valid !== 1'b0 || bus2.out_data !== 8'h00) begin
         errors++;
         $display("FAIL mid_rst_out: got %b/%h want 0/00", bus2.out_valid, bus2.out_data);
      end
      rst = 1'b0;
      req_valid = 4'b1010;
      out_ready = 1'b1;
      #1;
      // With ptr back at 3 the scan starts at channel 0, so channel 1 wins.
      checks++;
      if (bus2.req_ready !== 4'b0010 || bus2.sel_o !== 2'd1) begin
         errors++;
         $display("FAIL mid_ptr: got %b/%0d want 0010/1", bus2.req_ready, bus2.sel_o);
      end
      tick();
      checks++;
      if (bus2.out_data !== 8'h22 || bus2.grant_id !== 2'd1) begin
         errors++;
         $display("FAIL mid_after: got %h/%0d want 22/1", bus2.out_data, bus2.grant_id);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_backpressure();
      test_burst();
      test_wrap();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
